// File: rtl/tmr_sfr_ctrl.sv
// Purpose : 32-bit SFR-mapped timer with OFF/IDLE/RUN control, selectable
//           count-enable source, load/snapshot registers, two compare
//           registers and an overflow flag. Interrupts use enable masks.
// Latency : SFR reads are combinational. Writes take effect on the next
//           rising edge, and commands execute one cycle after that edge.
//           The interrupt is registered and follows its flag by one cycle.
// Backpressure : none; every selected write strobe is accepted.
// Ports   : sys_clk/sys_rst_n     clock, async active-low reset
//           sfr_addr/sfr_wr_en/sfr_wdata/sfr_rdata   register bus
//           clk_src_tick          eight count-enable pulse sources
//           tmr_irq, tmr_running  interrupt, state RUN indicator
module tmr_sfr_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] sfr_addr,
  input  logic        sfr_wr_en,
  input  logic [31:0] sfr_wdata,
  output logic [31:0] sfr_rdata,
  input  logic [7:0]  clk_src_tick,
  output logic        tmr_irq,
  output logic        tmr_running
);

  typedef enum logic [1:0] {ST_OFF, ST_IDLE, ST_RUN} state_t;

  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_VAL    = 2'd1;
  localparam logic [1:0] OFS_MATCH0 = 2'd2;
  localparam logic [1:0] OFS_MATCH1 = 2'd3;

  state_t      state_q, state_d;
  logic        on_q;
  logic [2:0]  clksrc_q;
  logic        ovf_en_q, m0_en_q, m1_en_q;
  logic        ovf_f_q, m0_f_q, m1_f_q;
  logic [31:0] load_q, snap_q, match0_q, match1_q, cnt_q;
  // Command bits captured by a CTRL write; they execute in the next cycle.
  logic        cmd_start_q, cmd_stop_q, cmd_rd_q, cmd_ld_q, cmd_rst_q;

  logic        sel, wr_ctrl, wr_val, wr_m0, wr_m1;
  logic        cmd_live, do_rst, do_ld, do_stop, do_start, do_rd, do_inc;
  logic [31:0] cnt_d;
  logic        cnt_upd, ovf_set, m0_set, m1_set;
  logic        unused_addr_lsb;

  assign sel     = (sfr_addr[31:4] == BASE_ADDR[31:4]);
  assign wr_ctrl = sfr_wr_en && sel && (sfr_addr[3:2] == OFS_CTRL);
  assign wr_val  = sfr_wr_en && sel && (sfr_addr[3:2] == OFS_VAL);
  assign wr_m0   = sfr_wr_en && sel && (sfr_addr[3:2] == OFS_MATCH0);
  assign wr_m1   = sfr_wr_en && sel && (sfr_addr[3:2] == OFS_MATCH1);
  assign unused_addr_lsb = ^sfr_addr[1:0];

  // Commands are dropped while OFF. Counter ops: rst beats ld.
  // State ops: stop beats start. Both groups and rd can act together.
  assign cmd_live = (state_q != ST_OFF);
  assign do_rst   = cmd_live && cmd_rst_q;
  assign do_ld    = cmd_live && cmd_ld_q && !cmd_rst_q;
  assign do_stop  = cmd_live && cmd_stop_q;
  assign do_start = cmd_live && cmd_start_q && !cmd_stop_q;
  assign do_rd    = cmd_live && cmd_rd_q;
  // A tick is lost only to an explicit counter overwrite in the same cycle.
  assign do_inc   = (state_q == ST_RUN) && clk_src_tick[clksrc_q] && !do_rst && !do_ld;

  always_comb begin
    cnt_d   = cnt_q;
    cnt_upd = 1'b0;
    ovf_set = 1'b0;
    if (do_rst) begin
      cnt_d   = 32'd0;
      cnt_upd = 1'b1;
    end else if (do_ld) begin
      cnt_d   = load_q;
      cnt_upd = 1'b1;
    end else if (do_inc) begin
      cnt_d   = cnt_q + 32'd1;
      cnt_upd = 1'b1;
      ovf_set = &cnt_q;
    end
  end

  assign m0_set = cnt_upd && (cnt_d == match0_q);
  assign m1_set = cnt_upd && (cnt_d == match1_q);

  // FSM: state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_OFF;
    else            state_q <= state_d;
  end

  // FSM: next state. Turning the block off overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:  if (wr_ctrl && sfr_wdata[0]) state_d = ST_IDLE;
      ST_IDLE: if (do_start)                state_d = ST_RUN;
      ST_RUN:  if (do_stop)                 state_d = ST_IDLE;
      default:                              state_d = ST_OFF;
    endcase
    if (wr_ctrl && !sfr_wdata[0]) state_d = ST_OFF;
  end

  // FSM: outputs
  always_comb begin
    tmr_running = (state_q == ST_RUN);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      on_q        <= 1'b0;
      clksrc_q    <= 3'd0;
      ovf_en_q    <= 1'b0;
      m0_en_q     <= 1'b0;
      m1_en_q     <= 1'b0;
      ovf_f_q     <= 1'b0;
      m0_f_q      <= 1'b0;
      m1_f_q      <= 1'b0;
      cmd_start_q <= 1'b0;
      cmd_stop_q  <= 1'b0;
      cmd_rd_q    <= 1'b0;
      cmd_ld_q    <= 1'b0;
      cmd_rst_q   <= 1'b0;
      load_q      <= 32'd0;
      snap_q      <= 32'd0;
      match0_q    <= 32'd0;
      match1_q    <= 32'd0;
      cnt_q       <= 32'd0;
      tmr_irq     <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        on_q     <= sfr_wdata[0];
        clksrc_q <= sfr_wdata[10:8];
        ovf_en_q <= sfr_wdata[23];
        m0_en_q  <= sfr_wdata[22];
        m1_en_q  <= sfr_wdata[21];
      end
      cmd_start_q <= wr_ctrl && sfr_wdata[7];
      cmd_stop_q  <= wr_ctrl && sfr_wdata[6];
      cmd_rd_q    <= wr_ctrl && sfr_wdata[3];
      cmd_ld_q    <= wr_ctrl && sfr_wdata[2];
      cmd_rst_q   <= wr_ctrl && sfr_wdata[1];
      // Write-1-to-clear, with a simultaneous hardware set taking priority.
      ovf_f_q <= ovf_set || (ovf_f_q && !(wr_ctrl && sfr_wdata[15]));
      m1_f_q  <= m1_set  || (m1_f_q  && !(wr_ctrl && sfr_wdata[14]));
      m0_f_q  <= m0_set  || (m0_f_q  && !(wr_ctrl && sfr_wdata[13]));
      if (wr_val) load_q   <= sfr_wdata;
      if (wr_m0)  match0_q <= sfr_wdata;
      if (wr_m1)  match1_q <= sfr_wdata;
      if (do_rd)  snap_q   <= cnt_q;
      cnt_q   <= cnt_d;
      tmr_irq <= (ovf_f_q && ovf_en_q) || (m0_f_q && m0_en_q) || (m1_f_q && m1_en_q);
    end
  end

  always_comb begin
    sfr_rdata = 32'd0;
    if (sel) begin
      case (sfr_addr[3:2])
        OFS_CTRL:   sfr_rdata = {8'd0, ovf_en_q, m0_en_q, m1_en_q, 5'd0,
                                 ovf_f_q, m1_f_q, m0_f_q, 2'd0, clksrc_q, 7'd0, on_q};
        OFS_VAL:    sfr_rdata = snap_q;
        OFS_MATCH0: sfr_rdata = match0_q;
        OFS_MATCH1: sfr_rdata = match1_q;
        default:    sfr_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_tmr_sfr_ctrl.sv
// Purpose : directed bench for tmr_sfr_ctrl with a queue-based scoreboard.
// Latency : expectations are queued by the stimulus; the monitor checks them
//           on the falling edge of each cycle the stimulus flags as sampled.
// Backpressure : none.
module tb_tmr_sfr_ctrl;

  localparam logic [31:0] BASE = 32'h4000_0010;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_VAL  = BASE + 32'h4;
  localparam logic [31:0] A_M0   = BASE + 32'h8;
  localparam logic [31:0] A_M1   = BASE + 32'hC;

  localparam int K_RDATA = 0;
  localparam int K_IRQ   = 1;
  localparam int K_RUN   = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [31:0] sfr_addr;
  logic        sfr_wr_en;
  logic [31:0] sfr_wdata;
  logic [31:0] sfr_rdata;
  logic [7:0]  clk_src_tick;
  logic        tmr_irq;
  logic        tmr_running;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  logic chk_vld = 1'b0;
  logic done    = 1'b0;

  tmr_sfr_ctrl #(.BASE_ADDR(BASE)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .sfr_addr     (sfr_addr),
    .sfr_wr_en    (sfr_wr_en),
    .sfr_wdata    (sfr_wdata),
    .sfr_rdata    (sfr_rdata),
    .clk_src_tick (clk_src_tick),
    .tmr_irq      (tmr_irq),
    .tmr_running  (tmr_running)
  );

  always #5 sys_clk = ~sys_clk;

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    sfr_addr  = a;
    sfr_wdata = d;
    sfr_wr_en = 1'b1;
    cyc();
    sfr_wr_en = 1'b0;
  endtask

  task automatic tick(input int src, input int n);
    for (int i = 0; i < n; i++) begin
      clk_src_tick = 8'(1 << src);
      cyc();
    end
    clk_src_tick = 8'd0;
  endtask

  function automatic void push(input int k, input logic [31:0] x, input string nm);
    exp_t t;
    t.kind = k;
    t.exp  = x;
    t.name = nm;
    exp_q.push_back(t);
  endfunction

  task automatic sample();
    chk_vld = 1'b1;
    cyc();
    chk_vld = 1'b0;
  endtask

  task automatic expect_rd(input logic [31:0] a, input logic [31:0] x, input string nm);
    sfr_addr = a;
    push(K_RDATA, x, nm);
    sample();
  endtask

  // Monitor / scoreboard
  initial begin
    int   n_checks;
    int   n_fail;
    exp_t e;
    logic [31:0] act;
    n_checks = 0;
    n_fail   = 0;
    forever begin
      @(negedge sys_clk);
      if (chk_vld) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL no_expect: sample requested with empty scoreboard");
        end
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          case (e.kind)
            K_IRQ:   act = {31'd0, tmr_irq};
            K_RUN:   act = {31'd0, tmr_running};
            default: act = sfr_rdata;
          endcase
          n_checks++;
          if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
          end
        end
      end
      if (done) begin
        if (exp_q.size() != 0) begin
          n_fail++;
          $display("FAIL leftover: %0d expectations never sampled", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
      end
    end
  end

  // Stimulus
  initial begin
    sys_rst_n    = 1'b0;
    sfr_addr     = 32'd0;
    sfr_wr_en    = 1'b0;
    sfr_wdata    = 32'd0;
    clk_src_tick = 8'd0;
    repeat (2) @(posedge sys_clk);
    #1;

    // Reset state
    sfr_addr = A_CTRL;
    push(K_RDATA, 32'd0, "rst_ctrl");
    push(K_IRQ,   32'd0, "rst_irq");
    push(K_RUN,   32'd0, "rst_run");
    sample();
    sys_rst_n = 1'b1;

    // First write right after release; plain R/W compare register
    wr(A_M1, 32'hA5A5_0001);
    expect_rd(A_M1, 32'hA5A5_0001, "m1_rw");

    // Unselected block: write ignored, read returns 0
    wr(32'h4000_0028, 32'hFFFF_FFFF);
    expect_rd(32'h4000_0028, 32'd0, "unsel_rd");
    expect_rd(A_M0, 32'd0, "unsel_wr");
    wr(A_M0, 32'h0000_1000);

    // Unimplemented CTRL bits read 0
    wr(A_CTRL, 32'hFFFF_FF31);
    expect_rd(A_CTRL, 32'h00E0_0701, "ctrl_mask");
    wr(A_CTRL, 32'd0);
    push(K_RUN, 32'd0, "off_run");
    sample();

    // on+start, clksrc=1, count 5 ticks; ticks on src0 ignored
    wr(A_CTRL, 32'h0000_0181);
    cyc();
    tick(1, 5);
    tick(0, 2);
    wr(A_CTRL, 32'h0000_0109);
    cyc();
    expect_rd(A_VAL, 32'd5, "rd_snap");
    push(K_RUN, 32'd1, "run_1");
    sample();
    expect_rd(A_CTRL, 32'h0000_0101, "cmd_rd0");

    // Overflow wrap
    wr(A_CTRL, 32'h0000_0141);
    wr(A_VAL, 32'hFFFF_FFFE);
    expect_rd(A_VAL, 32'd5, "val_snap_only");
    wr(A_CTRL, 32'h0080_0105);
    wr(A_CTRL, 32'h0080_0181);
    cyc();
    tick(1, 2);
    push(K_IRQ, 32'd0, "irq_lat");
    sample();
    push(K_IRQ, 32'd1, "ovf_irq");
    sample();
    expect_rd(A_CTRL, 32'h0080_8101, "ovf_flag");
    wr(A_CTRL, 32'h0080_0109);
    cyc();
    expect_rd(A_VAL, 32'd0, "ovf_wrap");
    wr(A_CTRL, 32'h0000_8101);

    // Match0 with enable off, then on, then W1C
    wr(A_M0, 32'd3);
    tick(1, 3);
    expect_rd(A_CTRL, 32'h0000_2101, "m0_flag");
    push(K_IRQ, 32'd0, "m0_noen");
    sample();
    wr(A_CTRL, 32'h0040_0101);
    cyc();
    push(K_IRQ, 32'd1, "m0_irq");
    sample();
    wr(A_CTRL, 32'h0040_2101);
    expect_rd(A_CTRL, 32'h0040_0101, "m0_w1c");
    push(K_IRQ, 32'd0, "m0_irq_clr");
    sample();

    // Match1 hardware set coinciding with W1C
    wr(A_M1, 32'd5);
    tick(1, 2);
    expect_rd(A_CTRL, 32'h0040_4101, "m1_flag");
    wr(A_VAL, 32'd5);
    wr(A_CTRL, 32'h0040_0105);
    wr(A_CTRL, 32'h0040_4101);
    expect_rd(A_CTRL, 32'h0040_4101, "m1_set_wins");
    wr(A_CTRL, 32'h0000_4101);
    expect_rd(A_CTRL, 32'h0000_0101, "m1_clr");

    // rst|ld|stop|start together while running
    wr(A_CTRL, 32'h0000_01C7);
    cyc();
    push(K_RUN, 32'd0, "cmd_stop");
    sample();
    tick(1, 2);
    wr(A_CTRL, 32'h0000_0109);
    cyc();
    expect_rd(A_VAL, 32'd0, "cmd_rst");

    // Asynchronous reset during RUN with an active interrupt
    wr(A_CTRL, 32'h0040_0181);
    cyc();
    tick(1, 3);
    cyc();
    push(K_IRQ, 32'd1, "pre_rst_irq");
    push(K_RUN, 32'd1, "pre_rst_run");
    sample();
    sys_rst_n = 1'b0;
    sfr_addr  = A_CTRL;
    push(K_RDATA, 32'd0, "arst_rdata");
    push(K_IRQ,   32'd0, "arst_irq");
    push(K_RUN,   32'd0, "arst_run");
    sample();
    sys_rst_n = 1'b1;
    push(K_RUN, 32'd0, "off_after_rst");
    sample();
    tick(1, 2);
    wr(A_CTRL, 32'h0000_0109);
    cyc();
    expect_rd(A_VAL, 32'd0, "off_nocount");

    done = 1'b1;
  end

endmodule
